ucie_ctl_tx_fdi_to_rdi: RTL and testbench

- Transmit-direction datapath between the protocol-side FDI and the RDI.
- Accepts flits from the protocol layer and buffers them in a small FIFO.
- Drives lp_valid/lp_irdy/lp_data toward the PHY, honouring pl_trdy backpressure.
- Gates traffic on the PHY-reported link state; holds buffered data during Retrain and flushes it on LinkError/Reset. Counterpart of the RX datapath (RDI to FDI).

---
 rtl/ucie_ctl_pkg.sv | 24 ++
 rtl/ucie_ctl_tx_fdi_to_rdi_if.sv | 41 ++++
 rtl/ucie_ctl_tx_fifo.sv | 48 ++++
 rtl/ucie_ctl_tx_fdi_to_rdi.sv | 115 +++++++++++
 tb/tb_ucie_ctl_tx_fdi_to_rdi.sv | 205 ++++++++++++++++++++
 5 files changed

// File: rtl/ucie_ctl_pkg.sv
// Shared UCIe controller definitions: RDI link-state encoding, TX FSM states, parity helper.
// Used by ucie_ctl_tx_fdi_to_rdi (optional parity build via UCIE_CTL_TX_PARITY_EN).
package ucie_ctl_pkg;

    typedef enum logic [3:0] {
        RESET     = 4'b0000,
        ACTIVE    = 4'b0001,
        LINKERROR = 4'b1010,
        RETRAIN   = 4'b1011
    } link_state_e;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACTIVE = 2'd1,
        S_HOLD   = 2'd2,
        S_FLUSH  = 2'd3
    } tx_state_e;

    // Even parity bit: set when the byte has an odd number of ones.
    function automatic logic byte_parity(input logic [7:0] b);
        return ^b;
    endfunction

endpackage

// File: rtl/ucie_ctl_tx_fdi_to_rdi_if.sv
// FDI/RDI transmit-side signal bundle; the datapath uses the slave modport.
// With UCIE_CTL_TX_PARITY_EN defined an extra per-byte parity output is carried.
interface ucie_ctl_tx_fdi_to_rdi_if #(
    parameter int NBYTES = 8,
    parameter int DEPTH  = 4
);
    localparam int CW = $clog2(DEPTH) + 1;

    logic [3:0]          i_rdi_pl_state_sts;
    logic                i_fdi_lp_valid;
    logic [NBYTES*8-1:0] i_fdi_lp_data;
    logic                o_fdi_pl_trdy;
    logic                o_rdi_lp_valid;
    logic                o_rdi_lp_irdy;
    logic [NBYTES*8-1:0] o_rdi_lp_data;
    logic                i_rdi_pl_trdy;
    logic [CW-1:0]       o_fifo_count;
    logic                o_overflow_detected;
`ifdef UCIE_CTL_TX_PARITY_EN
    logic [NBYTES-1:0]   o_rdi_lp_parity;
`endif

    modport slave (
        input  i_rdi_pl_state_sts, i_fdi_lp_valid, i_fdi_lp_data, i_rdi_pl_trdy,
        output o_fdi_pl_trdy, o_rdi_lp_valid, o_rdi_lp_irdy, o_rdi_lp_data,
               o_fifo_count, o_overflow_detected
`ifdef UCIE_CTL_TX_PARITY_EN
        , output o_rdi_lp_parity
`endif
    );

    modport master (
        output i_rdi_pl_state_sts, i_fdi_lp_valid, i_fdi_lp_data, i_rdi_pl_trdy,
        input  o_fdi_pl_trdy, o_rdi_lp_valid, o_rdi_lp_irdy, o_rdi_lp_data,
               o_fifo_count, o_overflow_detected
`ifdef UCIE_CTL_TX_PARITY_EN
        , input o_rdi_lp_parity
`endif
    );

endinterface

// File: rtl/ucie_ctl_tx_fifo.sv
// Synchronous show-ahead FIFO with wrap-bit pointers and a synchronous flush.
// Head word reads as zero while empty; storage itself is never reset.
module ucie_ctl_tx_fifo #(
    parameter int WIDTH = 64,
    parameter int DEPTH = 4,
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             rd_en,
    output logic [WIDTH-1:0] rd_data,
    output logic             full,
    output logic             empty,
    output logic [AW:0]      count
);
    logic [AW:0]      wr_ptr_r;
    logic [AW:0]      rd_ptr_r;
    logic [WIDTH-1:0] mem_r [DEPTH];
    logic             wr_ok_s;
    logic             rd_ok_s;

    assign full    = (wr_ptr_r[AW] != rd_ptr_r[AW]) && (wr_ptr_r[AW-1:0] == rd_ptr_r[AW-1:0]);
    assign empty   = (wr_ptr_r == rd_ptr_r);
    assign count   = wr_ptr_r - rd_ptr_r;
    assign wr_ok_s = wr_en && !full;
    assign rd_ok_s = rd_en && !empty;
    assign rd_data = empty ? {WIDTH{1'b0}} : mem_r[rd_ptr_r[AW-1:0]];

    // Pointer update; flush discards all buffered entries.
    always_ff @(posedge clk) begin
        if (!rst_n || flush) begin
            wr_ptr_r <= {(AW+1){1'b0}};
            rd_ptr_r <= {(AW+1){1'b0}};
        end else begin
            if (wr_ok_s) wr_ptr_r <= wr_ptr_r + {{AW{1'b0}}, 1'b1};
            if (rd_ok_s) rd_ptr_r <= rd_ptr_r + {{AW{1'b0}}, 1'b1};
        end
    end

    // Storage write.
    always_ff @(posedge clk) begin
        if (wr_ok_s) mem_r[wr_ptr_r[AW-1:0]] <= wr_data;
    end

endmodule

// File: rtl/ucie_ctl_tx_fdi_to_rdi.sv
// UCIe TX datapath FDI -> RDI: buffers protocol flits and forwards them under link-state gating.
// Define UCIE_CTL_TX_PARITY_EN to store and emit per-byte even parity alongside the data.
module ucie_ctl_tx_fdi_to_rdi
    import ucie_ctl_pkg::*;
#(
    parameter int NBYTES = 8,
    parameter int DEPTH  = 4
) (
    input logic                     i_clk,
    input logic                     i_rst_n,
    ucie_ctl_tx_fdi_to_rdi_if.slave bus
);
    localparam int DW = NBYTES * 8;
`ifdef UCIE_CTL_TX_PARITY_EN
    localparam int SW = NBYTES * 9;
`else
    localparam int SW = DW;
`endif
    localparam int CW = $clog2(DEPTH) + 1;

    tx_state_e     state_r;
    tx_state_e     state_next_s;
    logic          active_s;
    logic          full_s;
    logic          empty_s;
    logic          trdy_s;
    logic          valid_s;
    logic          wr_en_s;
    logic          rd_en_s;
    logic          flush_s;
    logic          overflow_r;
    logic [SW-1:0] wr_word_s;
    logic [SW-1:0] rd_word_s;
    logic [CW-1:0] count_s;

    // FSM state register.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) state_r <= S_IDLE;
        else          state_r <= state_next_s;
    end

    // Next state from the sampled link state; non-Active, non-fatal states park in HOLD.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            S_IDLE: begin
                if (bus.i_rdi_pl_state_sts == ACTIVE) state_next_s = S_ACTIVE;
                else                                  state_next_s = S_IDLE;
            end
            S_ACTIVE, S_HOLD: begin
                if (bus.i_rdi_pl_state_sts == ACTIVE)
                    state_next_s = S_ACTIVE;
                else if ((bus.i_rdi_pl_state_sts == LINKERROR) || (bus.i_rdi_pl_state_sts == RESET))
                    state_next_s = S_FLUSH;
                else
                    state_next_s = S_HOLD;
            end
            S_FLUSH: state_next_s = S_IDLE;
            default: state_next_s = S_IDLE;
        endcase
    end

    assign active_s = (state_r == S_ACTIVE);
    assign flush_s  = (state_r == S_FLUSH);
    assign trdy_s   = active_s && !full_s;
    assign valid_s  = active_s && !empty_s;
    assign wr_en_s  = bus.i_fdi_lp_valid && trdy_s;
    assign rd_en_s  = valid_s && bus.i_rdi_pl_trdy;

    // Sticky overflow: a beat offered while full in ACTIVE is dropped.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n)                                         overflow_r <= 1'b0;
        else if (bus.i_fdi_lp_valid && full_s && active_s)    overflow_r <= 1'b1;
    end

`ifdef UCIE_CTL_TX_PARITY_EN
    logic [NBYTES-1:0] wr_par_s;

    // Parity computed once at write time and stored with the data.
    always_comb begin
        wr_par_s = {NBYTES{1'b0}};
        for (int b = 0; b < NBYTES; b++) begin
            wr_par_s[b] = byte_parity(bus.i_fdi_lp_data[b*8 +: 8]);
        end
    end
    assign wr_word_s           = {wr_par_s, bus.i_fdi_lp_data};
    assign bus.o_rdi_lp_parity = rd_word_s[SW-1:DW];
`else
    assign wr_word_s = bus.i_fdi_lp_data;
`endif

    ucie_ctl_tx_fifo #(
        .WIDTH (SW),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (i_clk),
        .rst_n   (i_rst_n),
        .flush   (flush_s),
        .wr_en   (wr_en_s),
        .wr_data (wr_word_s),
        .rd_en   (rd_en_s),
        .rd_data (rd_word_s),
        .full    (full_s),
        .empty   (empty_s),
        .count   (count_s)
    );

    assign bus.o_fdi_pl_trdy       = trdy_s;
    assign bus.o_rdi_lp_valid      = valid_s;
    assign bus.o_rdi_lp_irdy       = valid_s;
    assign bus.o_rdi_lp_data       = rd_word_s[DW-1:0];
    assign bus.o_fifo_count        = count_s;
    assign bus.o_overflow_detected = overflow_r;

endmodule

// File: tb/tb_ucie_ctl_tx_fdi_to_rdi.sv
// Bench for ucie_ctl_tx_fdi_to_rdi: queue-based reference model checked every cycle,
// directed scenarios with literal expectations, then randomized traffic and link-state changes.
module tb_ucie_ctl_tx_fdi_to_rdi;
    localparam int NB    = 8;
    localparam int DEPTH = 4;
    localparam int M_IDLE = 0, M_ACT = 1, M_HOLD = 2, M_FLUSH = 3;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    ucie_ctl_tx_fdi_to_rdi_if #(.NBYTES(NB), .DEPTH(DEPTH)) bus ();

    ucie_ctl_tx_fdi_to_rdi #(.NBYTES(NB), .DEPTH(DEPTH)) dut (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .bus     (bus)
    );

    int          checks = 0;
    int          errors = 0;
    logic [63:0] mq[$];
    int          mode   = M_IDLE;
    bit          movf   = 1'b0;
    bit          cmp_en = 1'b0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
        end
    endtask

    // Advance the reference model across one clock edge using the held inputs.
    task automatic model_update();
        int s;
        int sz;
        bit act;
        bit wr;
        bit rd;
        s   = int'(bus.i_rdi_pl_state_sts);
        sz  = mq.size();
        act = (mode == M_ACT);
        if (!rst_n) begin
            mq.delete();
            mode = M_IDLE;
            movf = 1'b0;
        end else begin
            wr = bus.i_fdi_lp_valid && act && (sz < DEPTH);
            rd = act && (sz > 0) && bus.i_rdi_pl_trdy;
            if (bus.i_fdi_lp_valid && act && (sz == DEPTH)) movf = 1'b1;
            if (mode == M_FLUSH) begin
                mq.delete();
            end else begin
                if (rd) void'(mq.pop_front());
                if (wr) mq.push_back(bus.i_fdi_lp_data);
            end
            if (mode == M_FLUSH)        mode = M_IDLE;
            else if (mode == M_IDLE)    mode = (s == 1) ? M_ACT : M_IDLE;
            else if (s == 1)            mode = M_ACT;
            else if (s == 0 || s == 10) mode = M_FLUSH;
            else                        mode = M_HOLD;
        end
    endtask

    task automatic cyc(input bit rn, input logic [3:0] s, input bit v, input logic [63:0] d, input bit pt);
        rst_n                  = rn;
        bus.i_rdi_pl_state_sts = s;
        bus.i_fdi_lp_valid     = v;
        bus.i_fdi_lp_data      = d;
        bus.i_rdi_pl_trdy      = pt;
        @(posedge clk);
        #1;
        model_update();
    endtask

    // Every-cycle comparison of all outputs against the model.
    always @(negedge clk) begin
        if (cmp_en) begin
            logic [63:0] exp_d;
            bit          exp_v;
            exp_v = (mode == M_ACT) && (mq.size() > 0);
            exp_d = (mq.size() > 0) ? mq[0] : 64'd0;
            chk("m_valid", bus.o_rdi_lp_valid, exp_v);
            chk("m_irdy",  bus.o_rdi_lp_irdy, exp_v);
            chk("m_data",  bus.o_rdi_lp_data, exp_d);
            chk("m_trdy",  bus.o_fdi_pl_trdy, (mode == M_ACT) && (mq.size() < DEPTH));
            chk("m_count", bus.o_fifo_count, mq.size());
            chk("m_ovf",   bus.o_overflow_detected, movf);
`ifdef UCIE_CTL_TX_PARITY_EN
            begin
                logic [NB-1:0] exp_p;
                for (int b = 0; b < NB; b++) exp_p[b] = ^exp_d[b*8 +: 8];
                chk("m_parity", bus.o_rdi_lp_parity, exp_p);
            end
`endif
        end
    end

    initial begin
        logic [3:0] cur_sts;
        rst_n = 1'b0;
        bus.i_rdi_pl_state_sts = 4'd0;
        bus.i_fdi_lp_valid     = 1'b0;
        bus.i_fdi_lp_data      = 64'd0;
        bus.i_rdi_pl_trdy      = 1'b0;
        cyc(0, 4'd1, 1, 64'h1234, 1);
        cyc(0, 4'd1, 1, 64'h5678, 1);
        cmp_en = 1'b1;
        chk("rst_valid", bus.o_rdi_lp_valid, 0);
        chk("rst_trdy",  bus.o_fdi_pl_trdy, 0);
        chk("rst_count", bus.o_fifo_count, 0);
        chk("rst_data",  bus.o_rdi_lp_data, 0);
        chk("rst_ovf",   bus.o_overflow_detected, 0);

        // single beat, one-cycle latency
        cyc(1, 4'd1, 0, 64'd0, 0);
        chk("t1_trdy", bus.o_fdi_pl_trdy, 1);
        cyc(1, 4'd1, 1, 64'hA5A5_0000_0000_0001, 1);
        chk("t1_valid", bus.o_rdi_lp_valid, 1);
        chk("t1_data",  bus.o_rdi_lp_data, 64'hA5A5_0000_0000_0001);
        chk("t1_count", bus.o_fifo_count, 1);
        cyc(1, 4'd1, 0, 64'd0, 1);
        chk("t1_drain", bus.o_fifo_count, 0);

        // fill, overflow, drain in order
        for (int i = 0; i < 4; i++) cyc(1, 4'd1, 1, 64'h100 + 64'(i), 0);
        chk("t2_count", bus.o_fifo_count, 4);
        chk("t2_trdy",  bus.o_fdi_pl_trdy, 0);
        chk("t2_noovf", bus.o_overflow_detected, 0);
        cyc(1, 4'd1, 1, 64'hDEAD, 0);
        chk("t2_ovf",   bus.o_overflow_detected, 1);
        for (int i = 0; i < 4; i++) begin
            chk("t2_order", bus.o_rdi_lp_data, 64'h100 + 64'(i));
            cyc(1, 4'd1, 0, 64'd0, 1);
        end
        chk("t2_empty",  bus.o_fifo_count, 0);
        chk("t2_sticky", bus.o_overflow_detected, 1);

        // retrain holds contents
        cyc(1, 4'd1, 1, 64'h300, 0);
        cyc(1, 4'd1, 1, 64'h301, 0);
        cyc(1, 4'd11, 0, 64'd0, 0);
        chk("t3_valid", bus.o_rdi_lp_valid, 0);
        chk("t3_count", bus.o_fifo_count, 2);
        cyc(1, 4'd11, 1, 64'hBAD, 1);
        chk("t3_hold", bus.o_fifo_count, 2);
        cyc(1, 4'd1, 0, 64'd0, 0);
        chk("t3_resume", bus.o_rdi_lp_data, 64'h300);
        cyc(1, 4'd1, 0, 64'd0, 1);
        chk("t3_second", bus.o_rdi_lp_data, 64'h301);
        cyc(1, 4'd1, 0, 64'd0, 1);

        // link error flushes
        for (int i = 0; i < 3; i++) cyc(1, 4'd1, 1, 64'h400 + 64'(i), 0);
        cyc(1, 4'd10, 0, 64'd0, 0);
        chk("t4_valid", bus.o_rdi_lp_valid, 0);
        cyc(1, 4'd10, 0, 64'd0, 0);
        chk("t4_count", bus.o_fifo_count, 0);
        cyc(1, 4'd1, 0, 64'd0, 0);
        cyc(1, 4'd1, 1, 64'h500, 0);
        chk("t4_new", bus.o_rdi_lp_data, 64'h500);
        cyc(1, 4'd1, 0, 64'd0, 1);

        // simultaneous read/write at count 2, across pointer wrap
        cyc(1, 4'd1, 1, 64'h600, 0);
        cyc(1, 4'd1, 1, 64'h601, 0);
        for (int i = 0; i < 10; i++) begin
            cyc(1, 4'd1, 1, 64'h700 + 64'(i), 1);
            chk("t5_count", bus.o_fifo_count, 2);
        end
        chk("t5_head", bus.o_rdi_lp_data, 64'h708);
        cyc(1, 4'd1, 0, 64'd0, 1);
        cyc(1, 4'd1, 0, 64'd0, 1);

`ifdef UCIE_CTL_TX_PARITY_EN
        cyc(1, 4'd1, 1, 64'h0000_0000_0000_0307, 0);
        chk("t6_parity", bus.o_rdi_lp_parity[1:0], 2'b01);
        cyc(1, 4'd1, 0, 64'd0, 1);
`endif

        // randomized traffic with sticky link-state changes and rare resets
        cur_sts = 4'd1;
        for (int n = 0; n < 3000; n++) begin
            if ($urandom_range(0, 9) == 0) begin
                case ($urandom_range(0, 9))
                    0, 1, 2, 3, 4: cur_sts = 4'd1;
                    5, 6:          cur_sts = 4'd11;
                    7:             cur_sts = 4'd10;
                    8:             cur_sts = 4'd0;
                    default:       cur_sts = 4'd3;
                endcase
            end
            cyc(($urandom_range(0, 199) != 0), cur_sts, ($urandom_range(0, 3) != 0),
                {$urandom, $urandom}, ($urandom_range(0, 2) != 0));
        end

        @(negedge clk);
        cmp_en = 1'b0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
